i2c_reg_bank: RTL and testbench
===============================

Name: i2c_reg_bank

Overview:
- Downstream consumer of the I2C slave byte stream; turns write transactions into a register bank that drives configuration outputs.
- Takes each received byte (data, strobe) and the slave's bus-idle flag.
- Byte 0 of a frame is the address/RW byte, byte 1 is the register pointer, bytes 2+ are write data with pointer auto-increment.
- Exposes all registers flattened, plus a per-write strobe and frame-level status.

Parameters:
- NUM_REGS, 16: number of 8-bit registers, 1..256.
- RESET_VAL, 8'h00: value loaded into every register on reset.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- in_data  in  8  received byte from the slave; valid when in_ena=1.
- in_ena  in  1  single-cycle byte strobe.
- in_ready  in  1  slave bus-idle flag: 1 = no transfer, 0 = transfer in progress (between START and STOP).
- regs_flat  out  NUM_REGS*8  register contents; reg k occupies bits [8k+7:8k].
- wr_stb  out  1  one-cycle pulse per accepted register write.
- wr_addr  out  8  index of the register written (valid with wr_stb).
- wr_data  out  8  byte written (valid with wr_stb).
- frame_done  out  1  one-cycle pulse at frame end if the frame wrote at least one register.
- frame_err  out  1  set if the frame addressed out-of-range registers; held until the next frame start.

Behaviour:
- Reset values: every register = RESET_VAL; wr_stb=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0; internal ptr=0, byte_idx=0, rd_frame=0, any_wr=0; ready_d=1.
- Frame edges:
  - ready_d registers in_ready.
  - frame_start = ready_d & !in_ready.
  - frame_end = !ready_d & in_ready.
- On frame_start:
  - byte_idx=0, any_wr=0, rd_frame=0, frame_err=0.
  - An in_ena in the same cycle is processed as byte 0 after this clear.
- Byte handling on in_ena (only while in_ready=0; strobes while idle are ignored):
  - idx 0: rd_frame <= in_data[0] (the R/W bit). Address bits are not checked; the slave already filters them. idx -> 1.
  - idx 1, rd_frame=0: ptr <= in_data. idx -> 2.
  - idx >= 2, rd_frame=0:
    - If ptr < NUM_REGS: reg[ptr] <= in_data; wr_stb=1, wr_addr=ptr, wr_data=in_data; any_wr=1.
    - Else: byte dropped and frame_err=1.
    - ptr then increments; ptr == NUM_REGS-1 wraps to 0; an out-of-range ptr increments saturating at 8'hFF (no wrap).
  - rd_frame=1: all bytes after idx 0 are ignored. No register change, no strobe.
  - byte_idx saturates at 2.
- Latency: wr_stb/wr_addr/wr_data and the updated regs_flat are visible one clk after the in_ena cycle. wr_stb is high exactly one cycle per accepted byte.
- Frame end: frame_done = any_wr for one cycle, driven the cycle after frame_end is detected. frame_err stays as is.
- Abort: a frame ending after byte 0 or 1 makes no write and gives frame_done=0. ptr keeps its last value; it is not used until a new pointer byte arrives.
- A repeated START with no STOP is not seen as in_ready rising. The new address byte is then treated as a data byte; this is a documented limitation.
- Reset mid-frame: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: I2C_REG_BANK_SHADOW_EN.
- Defined:
  - Writes go to a shadow array; regs_flat holds the live array.
  - On frame_end with any_wr=1 and frame_err=0, the whole shadow is copied to live in one cycle, the same cycle frame_done pulses.
  - A frame with frame_err=1 reloads shadow from live; none of its writes take effect.
  - wr_stb/wr_addr/wr_data still pulse per byte, reflecting shadow writes.
  - Reset loads RESET_VAL into both arrays.
- Undefined: no shadow array; live registers update per byte as described above.

Test Plan:
- Write frame: START, bytes 8'hA0, 8'h03, 8'h55, 8'hAA, STOP -> reg3=8'h55, reg4=8'hAA; two wr_stb pulses with wr_addr 3 then 4; frame_done=1 once; frame_err=0.
- Wrap: ptr 8'h0F (NUM_REGS=16), data 8'h11, 8'h22 -> reg15=8'h11, reg0=8'h22; wr_addr sequence 15, 0.
- Out of range: ptr 8'h20, data 8'h77 -> no register changes, no wr_stb, frame_err=1 after the byte and still 1 after STOP, cleared at next START.
- Read frame: bytes 8'hA1, 8'h05, 8'h66 -> no writes, frame_done=0, all regs unchanged.
- Reset mid-frame: after ptr byte 8'h02, assert n_rst low for 2 cycles, then send data 8'h99 and STOP -> reg2=RESET_VAL, no wr_stb; next full frame works normally.
- Shadow (with I2C_REG_BANK_SHADOW_EN): write 8'h5A to reg1 -> regs_flat unchanged until STOP, changes in the frame_done cycle; a frame writing reg1 then an out-of-range byte -> reg1 live unchanged.

Source files
------------

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: register bank loaded from I2C slave write frames (addr, pointer, data...).
// Define I2C_REG_BANK_SHADOW_EN to stage writes in a shadow array committed at frame end.
module i2c_reg_bank #(
   parameter int         NUM_REGS  = 16,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [7:0]            in_data,
   input  logic                  in_ena,
   input  logic                  in_ready,
   output logic [NUM_REGS*8-1:0] regs_flat,
   output logic                  wr_stb,
   output logic [7:0]            wr_addr,
   output logic [7:0]            wr_data,
   output logic                  frame_done,
   output logic                  frame_err
);
   localparam logic [8:0] NR = 9'(NUM_REGS);
   logic [NUM_REGS-1:0][7:0] bank;
   logic [7:0] ptr, ptr_nxt;
   logic [1:0] byte_idx, cur_idx;
   logic rd_frame, any_wr, ready_d;
   logic frame_start, frame_end, byte_ok, cur_rd, data_byte, in_range, wr_hit;

   assign frame_start = ready_d & ~in_ready;
   assign frame_end   = ~ready_d & in_ready;
   assign byte_ok     = in_ena & ~in_ready;
   // A strobe on the start cycle is byte 0 of the new frame, so it sees cleared state.
   assign cur_idx     = frame_start ? 2'd0 : byte_idx;
   assign cur_rd      = ~frame_start & rd_frame;
   assign data_byte   = byte_ok & (cur_idx == 2'd2) & ~cur_rd;
   assign in_range    = {1'b0, ptr} < NR;
   assign wr_hit      = data_byte & in_range;
   assign ptr_nxt     = ({1'b0, ptr} == NR - 9'd1) ? 8'd0 : (ptr == 8'hFF) ? 8'hFF : ptr + 8'd1;

`ifdef I2C_REG_BANK_SHADOW_EN
   logic [NUM_REGS-1:0][7:0] live;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst)
         live <= {NUM_REGS{RESET_VAL}};
      else if (frame_end & any_wr & ~frame_err)
         live <= bank;
   assign regs_flat = live;
`else
   assign regs_flat = bank;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bank       <= {NUM_REGS{RESET_VAL}};
         ptr        <= 8'd0;
         byte_idx   <= 2'd0;
         rd_frame   <= 1'b0;
         any_wr     <= 1'b0;
         ready_d    <= 1'b1;
         wr_stb     <= 1'b0;
         wr_addr    <= 8'd0;
         wr_data    <= 8'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         ready_d    <= in_ready;
         wr_stb     <= wr_hit;
         frame_done <= frame_end & any_wr;
         if (frame_start) begin
            byte_idx  <= 2'd0;
            any_wr    <= 1'b0;
            rd_frame  <= 1'b0;
            frame_err <= 1'b0;
         end
         if (byte_ok) begin
            if (cur_idx == 2'd0) rd_frame <= in_data[0];
            if (cur_idx == 2'd1 && !cur_rd) ptr <= in_data;
            if (cur_idx != 2'd2) byte_idx <= cur_idx + 2'd1;
         end
         if (data_byte) ptr <= ptr_nxt;
         if (data_byte & ~in_range) frame_err <= 1'b1;
         if (wr_hit) begin
            wr_addr <= ptr;
            wr_data <= in_data;
            any_wr  <= 1'b1;
         end
         for (int k = 0; k < NUM_REGS; k++)
            if (wr_hit && ptr == 8'(k)) bank[k] <= in_data;
`ifdef I2C_REG_BANK_SHADOW_EN
         if (frame_end & frame_err) bank <= live;
`endif
      end
   end
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed and random frames checked every cycle against a frame-level model.
// Honours I2C_REG_BANK_SHADOW_EN the same way the design does.
module tb_i2c_reg_bank;
   localparam int NR = 16;
   localparam int W = NR * 8;
   localparam logic [7:0] RV = 8'h00;

   logic clk = 0, n_rst;
   logic [7:0] in_data;
   logic in_ena, in_ready;
   logic [W-1:0] regs_flat;
   logic wr_stb, frame_done, frame_err;
   logic [7:0] wr_addr, wr_data;

   i2c_reg_bank #(.NUM_REGS(NR), .RESET_VAL(RV)) dut (
      .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_ena(in_ena), .in_ready(in_ready),
      .regs_flat(regs_flat), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int stb_cnt, done_cnt;
   logic [7:0] addr_log[$];
   logic [7:0] q[$];

   // model working state (frame level)
   logic [7:0] sh[NR], lv[NR];
   int cnt, ptr;
   bit rd, any, err, prev_rdy;
   // model view of outputs, published after each clock edge
   logic [W-1:0] e_regs, e_work;
   logic e_stb, e_done, e_err;
   logic [7:0] e_addr, e_data;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("regs_flat", regs_flat, e_regs);
      chk("wr_stb", W'(wr_stb), W'(e_stb));
      chk("wr_addr", W'(wr_addr), W'(e_addr));
      chk("wr_data", W'(wr_data), W'(e_data));
      chk("frame_done", W'(frame_done), W'(e_done));
      chk("frame_err", W'(frame_err), W'(e_err));
      if (wr_stb) begin
         stb_cnt++;
         addr_log.push_back(wr_addr);
      end
      if (frame_done) done_cnt++;
   end

   function automatic logic [W-1:0] pack_lv();
      logic [W-1:0] v;
      for (int k = 0; k < NR; k++) v[8*k +: 8] = lv[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NR; k++) begin
         sh[k] = RV;
         lv[k] = RV;
      end
      cnt = 0; ptr = 0; rd = 0; any = 0; err = 0; prev_rdy = 1;
      e_regs = pack_lv(); e_stb = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0;
   endtask

   task automatic step(input bit rdy, input bit ena, input logic [7:0] d);
      bit p_stb, p_done;
      logic [7:0] p_addr, p_data;
      in_ready = rdy; in_ena = ena; in_data = d;
      p_stb = 0; p_done = 0; p_addr = e_addr; p_data = e_data;
      if (prev_rdy && !rdy) begin
         cnt = 0; any = 0; rd = 0; err = 0;
      end
      if (!prev_rdy && rdy) begin
         p_done = any;
`ifdef I2C_REG_BANK_SHADOW_EN
         if (any && !err) lv = sh;
         else if (err) sh = lv;
`endif
      end
      if (ena && !rdy) begin
         if (cnt == 0) rd = d[0];
         else if (!rd && cnt == 1) ptr = d;
         else if (!rd) begin
            if (ptr < NR) begin
               sh[ptr] = d;
`ifndef I2C_REG_BANK_SHADOW_EN
               lv[ptr] = d;
`endif
               p_stb = 1; p_addr = 8'(ptr); p_data = d; any = 1;
            end else err = 1;
            ptr = (ptr == NR - 1) ? 0 : (ptr >= 255) ? 255 : ptr + 1;
         end
         cnt++;
      end
      prev_rdy = rdy;
      e_work = pack_lv();
      @(posedge clk);
      #1;
      e_regs = e_work; e_stb = p_stb; e_addr = p_addr; e_data = p_data; e_done = p_done; e_err = err;
   endtask

   task automatic send_q(input bit fast, input bit gaps);
      if (!fast) step(0, 0, 8'h00);
      foreach (q[i]) begin
         step(0, 1, q[i]);
         if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, 8'($urandom));
      end
   endtask

   task automatic stop();
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);
   endtask

   task automatic clr_logs();
      stb_cnt = 0; done_cnt = 0; addr_log.delete();
   endtask

   task automatic do_reset(input int n);
      n_rst = 0; in_ena = 0;
      model_reset();
      repeat (n) @(posedge clk);
      #1 n_rst = 1;
   endtask

   initial begin
      logic [W-1:0] snap;
      in_ready = 1; in_ena = 0; in_data = 0; n_rst = 0;
      model_reset();
      chk_en = 1;
      repeat (2) @(posedge clk);
      #1 n_rst = 1;
      chk("reset_regs", regs_flat, '0);
      chk("reset_err", W'(frame_err), '0);

      clr_logs();
      q = '{8'hA0, 8'h03, 8'h55, 8'hAA};
      send_q(0, 0); stop();
      chk("wr_reg3", W'(regs_flat[31:24]), W'(8'h55));
      chk("wr_reg4", W'(regs_flat[39:32]), W'(8'hAA));
      chk("wr_stb_count", W'(stb_cnt), W'(2));
      chk("wr_addr_first", W'(addr_log[0]), W'(8'd3));
      chk("wr_addr_second", W'(addr_log[1]), W'(8'd4));
      chk("wr_done_count", W'(done_cnt), W'(1));
      chk("wr_err", W'(frame_err), '0);

      clr_logs();
      q = '{8'hA0, 8'h0F, 8'h11, 8'h22};
      send_q(1, 0); stop();
      chk("wrap_reg15", W'(regs_flat[127:120]), W'(8'h11));
      chk("wrap_reg0", W'(regs_flat[7:0]), W'(8'h22));
      chk("wrap_addr_first", W'(addr_log[0]), W'(8'd15));
      chk("wrap_addr_second", W'(addr_log[1]), W'(8'd0));

      clr_logs();
      snap = regs_flat;
      q = '{8'hA0, 8'h20, 8'h77};
      send_q(0, 0);
      chk("oor_err_mid", W'(frame_err), W'(1));
      stop();
      chk("oor_err_after_stop", W'(frame_err), W'(1));
      chk("oor_regs", regs_flat, snap);
      chk("oor_stb_count", W'(stb_cnt), '0);
      chk("oor_done_count", W'(done_cnt), '0);
      step(0, 0, 8'h00);
      chk("oor_err_cleared", W'(frame_err), '0);
      stop();

      clr_logs();
      q = '{8'hA1, 8'h05, 8'h66};
      send_q(0, 0); stop();
      chk("rd_regs", regs_flat, snap);
      chk("rd_stb_count", W'(stb_cnt), '0);
      chk("rd_done_count", W'(done_cnt), '0);

      clr_logs();
      q = '{8'hA0, 8'h02};
      send_q(0, 0);
      do_reset(2);
      step(0, 1, 8'h99); stop();
      chk("rst_reg2", W'(regs_flat[23:16]), W'(RV));
      chk("rst_regs_all", regs_flat, '0);
      chk("rst_stb_count", W'(stb_cnt), '0);
      q = '{8'hA0, 8'h02, 8'h99};
      send_q(0, 0); stop();
      chk("rst_after_reg2", W'(regs_flat[23:16]), W'(8'h99));

`ifdef I2C_REG_BANK_SHADOW_EN
      q = '{8'hA0, 8'h01, 8'h5A};
      send_q(0, 0);
      chk("shadow_reg1_held", W'(regs_flat[15:8]), W'(8'h00));
      step(1, 0, 8'h00);
      chk("shadow_reg1_commit", W'(regs_flat[15:8]), W'(8'h5A));
      chk("shadow_done", W'(frame_done), W'(1));
      step(1, 0, 8'h00);
      snap = regs_flat;
      q = '{8'hA0, 8'h10, 8'h33};
      send_q(0, 0); stop();
      chk("shadow_err_regs", regs_flat, snap);
`endif

      for (int f = 0; f < 80; f++) begin
         int r;
         q.delete();
         q.push_back({7'h50, 1'($urandom_range(0, 4) == 0)});
         r = $urandom_range(0, 9);
         q.push_back(r < 6 ? 8'($urandom_range(0, NR - 1)) :
                     r < 8 ? 8'($urandom_range(NR - 3, NR - 1)) : 8'($urandom_range(NR, 255)));
         repeat ($urandom_range(0, 5)) q.push_back(8'($urandom));
         if ($urandom_range(0, 7) == 0) q = q[0:$urandom_range(0, 1)];
         send_q(1'($urandom_range(0, 1)), 1);
         stop();
         repeat ($urandom_range(0, 2)) step(1, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      stop();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
